// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared definitions for the register-file writeback arbiter: FSM encoding,
// requester count/indices, and small round-robin helpers.
package regfile_wb_arbiter_pkg;

   localparam int unsigned NUM_REQ = 3;
   localparam int unsigned REG_W   = 5;
   localparam int unsigned DATA_W  = 32;
   localparam int unsigned PTR_W   = 2;

   localparam logic [PTR_W-1:0] REQ_ALU   = 2'd0;
   localparam logic [PTR_W-1:0] REQ_LOAD  = 2'd1;
   localparam logic [PTR_W-1:0] REQ_DEBUG = 2'd2;

   localparam logic [REG_W-1:0] FIRST_CLEAR_REG = 5'd1;
   localparam logic [REG_W-1:0] LAST_CLEAR_REG  = 5'd31;

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_CLEAR = 1'b1
   } state_t;

   // Requester that follows idx in round-robin order (2 wraps to 0).
   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] idx);
      return (idx == REQ_DEBUG) ? REQ_ALU : PTR_W'(idx + 2'd1);
   endfunction

   // Index of the set bit in a one-hot grant (0 when empty).
   function automatic logic [PTR_W-1:0] grant_index(input logic [NUM_REQ-1:0] g);
      if (g[REQ_DEBUG])     return REQ_DEBUG;
      else if (g[REQ_LOAD]) return REQ_LOAD;
      else                  return REQ_ALU;
   endfunction

endpackage

// File: rtl/regfile_wb_arbiter_rr.sv
// rr_arbiter3: combinational three-way round-robin grant.
// Ports: valid   - request bits
//        pointer - highest-priority requester this cycle
//        grant   - one-hot grant, zero when no request
module rr_arbiter3
   import regfile_wb_arbiter_pkg::*;
(
   input  logic [NUM_REQ-1:0] valid,
   input  logic [PTR_W-1:0]   pointer,
   output logic [NUM_REQ-1:0] grant
);

   // Search order starts at pointer and wraps.
   always_comb begin
      grant = '0;
      case (pointer)
         REQ_LOAD: begin
            if (valid[1])      grant = 3'b010;
            else if (valid[2]) grant = 3'b100;
            else if (valid[0]) grant = 3'b001;
         end
         REQ_DEBUG: begin
            if (valid[2])      grant = 3'b100;
            else if (valid[0]) grant = 3'b001;
            else if (valid[1]) grant = 3'b010;
         end
         default: begin
            if (valid[0])      grant = 3'b001;
            else if (valid[1]) grant = 3'b010;
            else if (valid[2]) grant = 3'b100;
         end
      endcase
   end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register-file writeback arbiter: round-robin merges three write requesters
// (ALU, load, debug) into one registered write port, and runs a clear sweep
// writing CLEAR_VALUE to registers 1..31.
// Ports: clock, reset (sync, active-high)
//        req_valid/req_ready/req_reg/req_data - per-requester handshake
//        clear_start - pulse that starts a sweep
//        regwrite/write_reg/write_data - registered write port
//        busy - sweep in progress; clear_done - pulse on the reg-31 write
module regfile_wb_arbiter
   import regfile_wb_arbiter_pkg::*;
#(
   parameter logic [DATA_W-1:0] CLEAR_VALUE = 32'h0
)(
   input  logic                              clock,
   input  logic                              reset,
   input  logic [NUM_REQ-1:0]                req_valid,
   output logic [NUM_REQ-1:0]                req_ready,
   input  logic [NUM_REQ-1:0][REG_W-1:0]     req_reg,
   input  logic [NUM_REQ-1:0][DATA_W-1:0]    req_data,
   input  logic                              clear_start,
   output logic                              regwrite,
   output logic [REG_W-1:0]                  write_reg,
   output logic [DATA_W-1:0]                 write_data,
   output logic                              busy,
   output logic                              clear_done
);

   state_t               state, next_state;
   logic [PTR_W-1:0]     ptr, ptr_nx;
   logic [REG_W-1:0]     cnt, cnt_nx;
   logic [NUM_REQ-1:0]   grant;
   logic [PTR_W-1:0]     gidx;
   logic                 regwrite_nx;
   logic [REG_W-1:0]     write_reg_nx;
   logic [DATA_W-1:0]    write_data_nx;
   logic                 clear_done_nx;

   rr_arbiter3 u_rr (
      .valid   (req_valid),
      .pointer (ptr),
      .grant   (grant)
   );

   assign gidx = grant_index(grant);
   assign busy = (state != ST_IDLE);

   // State register.
   always_ff @(posedge clock) begin
      if (reset) state <= ST_IDLE;
      else       state <= next_state;
   end

   // Next-state logic; clear_start beats any request in IDLE.
   always_comb begin
      next_state = state;
      case (state)
         ST_IDLE:  if (clear_start) next_state = ST_CLEAR;
         ST_CLEAR: if (cnt == LAST_CLEAR_REG) next_state = ST_IDLE;
         default:  next_state = ST_IDLE;
      endcase
   end

   // Output/datapath next values; grant is only non-zero where valid is set,
   // so a non-zero grant in IDLE is a completed transfer.
   always_comb begin
      req_ready     = '0;
      regwrite_nx   = 1'b0;
      write_reg_nx  = write_reg;
      write_data_nx = write_data;
      clear_done_nx = 1'b0;
      ptr_nx        = ptr;
      cnt_nx        = cnt;
      case (state)
         ST_IDLE: begin
            if (clear_start) begin
               cnt_nx = FIRST_CLEAR_REG;
            end else begin
               req_ready = grant;
               if (|grant) begin
                  regwrite_nx   = (req_reg[gidx] != '0);
                  write_reg_nx  = req_reg[gidx];
                  write_data_nx = req_data[gidx];
                  ptr_nx        = next_ptr(gidx);
               end
            end
         end
         ST_CLEAR: begin
            regwrite_nx   = 1'b1;
            write_reg_nx  = cnt;
            write_data_nx = CLEAR_VALUE;
            cnt_nx        = REG_W'(cnt + 5'd1);
            clear_done_nx = (cnt == LAST_CLEAR_REG);
         end
         default: ;
      endcase
   end

   // Registered write port, pointer and sweep counter.
   always_ff @(posedge clock) begin
      if (reset) begin
         regwrite   <= 1'b0;
         write_reg  <= '0;
         write_data <= '0;
         clear_done <= 1'b0;
         ptr        <= REQ_ALU;
         cnt        <= '0;
      end else begin
         regwrite   <= regwrite_nx;
         write_reg  <= write_reg_nx;
         write_data <= write_data_nx;
         clear_done <= clear_done_nx;
         ptr        <= ptr_nx;
         cnt        <= cnt_nx;
      end
   end

endmodule
